ext_align_pipe: RTL and testbench
=================================

Name: ext_align_pipe

Overview:
- Parametrised, pipelined successor to the combinational 16-to-32 sign extender.
- Handles immediate extension (sign, zero, upper-load) and load-data byte/half/word selection with sign or zero extension.
- Registered output stage with a valid/ready handshake and a one-entry skid buffer.
- Flags misaligned and reserved operations, and counts errors.
- Sits between the memory read-data path / decode immediate field and the writeback or ALU operand mux of the MIPS datapath.

Parameters:
- XLEN, 32, output datapath width; legal values 32 or 64.
- IMM_W, 16, immediate field width; must be less than XLEN.
- BIG_ENDIAN, 0, 1 selects big-endian byte-lane numbering for loads.
- CNT_W, 8, error counter width.
- Derived localparam OFF_W = log2(XLEN/8): 2 for XLEN=32, 3 for XLEN=64.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- Mode  in  3  operation select: 0 imm sign, 1 imm zero, 2 imm upper (imm<<16, low bits zero, sign-extended above bit 31), 3 load byte, 4 load half, 5 load word, 6 load double (XLEN=64 only), 7 reserved.
- Unsigned  in  1  for modes 3-5: 1 zero-extends, 0 sign-extends; ignored for modes 0-2 and 6.
- Imm  in  IMM_W  immediate field.
- Data  in  XLEN  raw load word from memory.
- Offset  in  OFF_W  byte address low bits.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  XLEN  extended / aligned result.
- err  out  1  qualifies out: misaligned or reserved operation.
- err_count  out  CNT_W  saturating count of accepted errored requests.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out=0, err=0, err_count=0, skid buffer empty.
- in_ready = ~reset & ~skid_full (combinational). It is 0 during reset and 1 in the first cycle after reset deasserts.
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: a request accepted in cycle N appears on out/out_valid in cycle N+1 when the output register is empty or being drained in cycle N.
- Backpressure: if the output is held (out_valid & ~out_ready) and a request is accepted, the computed result goes to the skid buffer and in_ready drops the next cycle.
- Skid drain: when the output drains, the skid entry moves to the output register and in_ready returns high. The skid path adds no bubble.
- Ordering: strictly in order; no request is dropped or duplicated.
- Output stability: out/err hold constant while out_valid & ~out_ready.
- Lane select: lane index k = Offset when BIG_ENDIAN=0; k = (XLEN/8 - size_bytes) - Offset when BIG_ENDIAN=1 (size-aligned).
  - Byte = Data[8k+7:8k].
  - Half = Data[8k+15:8k].
  - Word = Data[8k+31:8k].
- Extension: sign-extend from the selected field's MSB unless Unsigned=1.
- Word extension on XLEN=32: pass-through. Word extension on XLEN=64: follows Unsigned.
- Alignment errors set err=1 and out=0:
  - half with Offset[0]=1;
  - word with Offset[1:0]≠0;
  - double with Offset≠0.
- Mode errors set err=1 and out=0: Mode 7, or Mode 6 with XLEN=32.
- err_count: increments by 1 on each accepted errored request, computed at input transfer time. It saturates at all-ones and never wraps.
- Reset mid-operation: output and skid contents are discarded. A request presented in the same cycle as reset is not accepted.
- Simultaneous out drain and new accept with an empty skid: the new result loads directly into the output register and out_valid stays 1.

Test Plan:
- XLEN=32, Mode0:
  - Imm=16'h8000 -> out=32'hFFFF8000.
  - Imm=16'hC017 -> 32'hFFFFC017.
  - Imm=16'h0017 -> 32'h00000017.
  - Mode1 Imm=16'h8007 -> 32'h00008007.
  - Mode2 Imm=16'h1234 -> 32'h12340000.
  - Each result arrives 1 cycle after accept, err=0.
- Data=32'h11C08007, little-endian:
  - Mode3 Offset=2 Unsigned=0 -> 32'hFFFFFFC0; Unsigned=1 -> 32'h000000C0.
  - Mode4 Offset=0 -> 32'hFFFF8007.
  - Mode5 Offset=0 -> 32'h11C08007.
  - With BIG_ENDIAN=1, Mode3 Offset=0 -> 32'h00000011.
- Errors:
  - Mode4 Offset=1 -> out=0, err=1, err_count=1.
  - Mode7 -> err=1, err_count=2.
  - With CNT_W=2, 5 errors -> err_count saturates at 3.
- Backpressure:
  - Stimulus: out_ready=0; send A, B, C back-to-back.
  - A holds on out; B goes to skid; in_ready=0 from the cycle after B is accepted; C waits upstream.
  - Raise out_ready: A, B, C emerge on consecutive cycles in order with no bubble.
- Reset mid-stream:
  - Assert reset with out_valid=1 and the skid full.
  - Next cycle: out_valid=0, out=0, err_count=0, in_ready=0.
  - First cycle after deassert: in_ready=1.
- XLEN=64:
  - Mode6 Offset=0 Data=64'h8000_0000_0000_0001 -> same value.
  - Mode5 Offset=4 Unsigned=0 Data upper word 32'h80000000 -> 64'hFFFFFFFF80000000.

Source files
------------

// File: rtl/ext_align_pipe_if.sv
// rtl/ext_align_pipe_if.sv - request/response handshake bundle for ext_align_pipe
interface ext_align_pipe_if #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16,
    parameter int CNT_W = 8
);
    localparam int OFF_W = $clog2(XLEN / 8);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       Mode;
    logic             Unsigned;
    logic [IMM_W-1:0] Imm;
    logic [XLEN-1:0]  Data;
    logic [OFF_W-1:0] Offset;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out;
    logic             err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, Mode, Unsigned, Imm, Data, Offset, out_ready,
        input  in_ready, out_valid, out, err, err_count
    );

    modport slave (
        input  in_valid, Mode, Unsigned, Imm, Data, Offset, out_ready,
        output in_ready, out_valid, out, err, err_count
    );
endinterface

// File: rtl/ext_align_pipe.sv
// rtl/ext_align_pipe.sv - immediate/load-data extender with registered output and skid buffer
module ext_align_pipe #(
    parameter int XLEN       = 32,
    parameter int IMM_W      = 16,
    parameter int BIG_ENDIAN = 0,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           reset,
    ext_align_pipe_if.slave bus
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int NB    = XLEN / 8;

    localparam logic [OFF_W:0]   NB_V     = (OFF_W + 1)'(NB);
    localparam logic [XLEN-1:0]  LOW8     = XLEN'(8'hFF);
    localparam logic [XLEN-1:0]  LOW16    = XLEN'(16'hFFFF);
    localparam logic [XLEN-1:0]  LOW32    = XLEN'(32'hFFFF_FFFF);
    localparam logic [XLEN-1:0]  IMM_MASK = (XLEN'(1) << IMM_W) - XLEN'(1);

    logic [OFF_W:0]   size_b;
    logic [OFF_W:0]   lane;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  mask;
    logic             msb;
    logic             res_err;
    logic [XLEN-1:0]  res_val;

    logic [XLEN-1:0]  out_q, out_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  skid_q, skid_d;
    logic             skid_err_q, skid_err_d;
    logic             skid_full_q, skid_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_ready;
    logic accept;
    logic drain;

    assign in_ready = ~reset & ~skid_full_q;
    assign accept   = bus.in_valid & in_ready;
    assign drain    = out_valid_q & bus.out_ready;

    // Result is built as (field & mask) with ~mask filled when the field's sign bit is to be replicated.
    always_comb begin
        size_b  = '0;
        base    = '0;
        mask    = '1;
        msb     = 1'b0;
        res_err = 1'b0;

        case (bus.Mode)
            3'd3:    size_b = (OFF_W + 1)'(1);
            3'd4:    size_b = (OFF_W + 1)'(2);
            3'd5:    size_b = (OFF_W + 1)'(4);
            3'd6:    size_b = NB_V;
            default: size_b = '0;
        endcase

        lane    = (BIG_ENDIAN != 0) ? (NB_V - size_b - {1'b0, bus.Offset}) : {1'b0, bus.Offset};
        shifted = bus.Data >> {lane, 3'b000};

        case (bus.Mode)
            3'd0: begin
                base = XLEN'(bus.Imm);
                mask = IMM_MASK;
                msb  = bus.Imm[IMM_W-1];
            end
            3'd1: begin
                base = XLEN'(bus.Imm);
                mask = IMM_MASK;
            end
            3'd2: begin
                base = XLEN'(bus.Imm) << 16;
                mask = LOW32;
                msb  = base[31];
            end
            3'd3: begin
                base = shifted;
                mask = LOW8;
                msb  = ~bus.Unsigned & shifted[7];
            end
            3'd4: begin
                base    = shifted;
                mask    = LOW16;
                msb     = ~bus.Unsigned & shifted[15];
                res_err = bus.Offset[0];
            end
            3'd5: begin
                base    = shifted;
                mask    = LOW32;
                msb     = ~bus.Unsigned & shifted[31];
                res_err = (bus.Offset[1:0] != 2'b00);
            end
            3'd6: begin
                base    = shifted;
                res_err = (XLEN == 32) || (bus.Offset != '0);
            end
            default: res_err = 1'b1;
        endcase

        res_val = res_err ? '0 : ((base & mask) | (msb ? ~mask : '0));
    end

    // The skid entry only fills while the output is held, so it always drains before new input.
    always_comb begin
        out_d       = out_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_err_d  = skid_err_q;
        skid_full_d = skid_full_q;
        cnt_d       = cnt_q;

        if (!out_valid_q || drain) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                err_d       = skid_err_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d       = res_val;
                err_d       = res_err;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = res_val;
            skid_err_d  = res_err;
            skid_full_d = 1'b1;
        end

        if (accept && res_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            skid_q      <= '0;
            skid_err_q  <= 1'b0;
            skid_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            skid_q      <= skid_d;
            skid_err_q  <= skid_err_d;
            skid_full_q <= skid_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.err       = err_q;
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_ext_align_pipe.sv
// tb/tb_ext_align_pipe.sv - scoreboard bench for ext_align_pipe (32-bit LE and 64-bit BE instances)
module tb_ext_align_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    ext_align_pipe_if #(.XLEN(32), .IMM_W(16), .CNT_W(8)) ia ();
    ext_align_pipe_if #(.XLEN(64), .IMM_W(16), .CNT_W(2)) ib ();

    ext_align_pipe #(.XLEN(32), .IMM_W(16), .BIG_ENDIAN(0), .CNT_W(8)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia)
    );
    ext_align_pipe #(.XLEN(64), .IMM_W(16), .BIG_ENDIAN(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib)
    );

    logic [64:0] q_a[$];
    logic [64:0] q_b[$];
    int cnt_a = 0;
    int cnt_b = 0;
    int errors = 0;
    int checks = 0;
    bit rand_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: gather size bytes starting at the lane, then extend; result is {err, value}.
    function automatic logic [64:0] model(input int xlen, input bit be, input logic [2:0] mode,
                                          input bit uns, input logic [15:0] imm,
                                          input logic [63:0] data, input int off);
        int nb, size, lane;
        logic [63:0] v, field;
        bit e;
        nb = xlen / 8;
        v  = '0;
        e  = 1'b0;
        case (mode)
            3'd0: v = {{48{imm[15]}}, imm};
            3'd1: v = {48'h0, imm};
            3'd2: v = {{32{imm[15]}}, imm, 16'h0};
            3'd7: e = 1'b1;
            default: begin
                size = 1 << (int'(mode) - 3);
                if (size > nb || (off % size) != 0) begin
                    e = 1'b1;
                end else begin
                    lane  = be ? (nb - size - off) : off;
                    field = '0;
                    for (int i = 0; i < size; i++) field[8*i +: 8] = data[8*(lane+i) +: 8];
                    v = field;
                    if (!uns && field[8*size-1]) begin
                        for (int i = 8 * size; i < 64; i++) v[i] = 1'b1;
                    end
                end
            end
        endcase
        if (e) v = '0;
        if (xlen == 32) v[63:32] = '0;
        return {e, v};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called and returns at posedge+1; the request is accepted at the first posedge with in_ready high.
    task automatic send(input bit which, input logic [2:0] mode, input bit uns, input logic [15:0] imm,
                        input logic [63:0] data, input int off, input logic [64:0] exp, input bit chk_lat);
        bit rdy, acc;
        acc = 1'b0;
        if (!which) begin
            ia.in_valid = 1'b1; ia.Mode = mode; ia.Unsigned = uns; ia.Imm = imm;
            ia.Data = data[31:0]; ia.Offset = off[1:0];
        end else begin
            ib.in_valid = 1'b1; ib.Mode = mode; ib.Unsigned = uns; ib.Imm = imm;
            ib.Data = data; ib.Offset = off[2:0];
        end
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            rdy = which ? ib.in_ready : ia.in_ready;
            if (rdy) begin
                if (which) begin
                    q_b.push_back(exp);
                    if (exp[64] && cnt_b < 3) cnt_b++;
                end else begin
                    q_a.push_back(exp);
                    if (exp[64] && cnt_a < 255) cnt_a++;
                end
            end
            @(posedge clk);
            acc = rdy;
        end
        #1;
        if (which) ib.in_valid = 1'b0; else ia.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
        if (chk_lat) begin
            @(negedge clk);
            check(which ? "b_latency" : "a_latency", 64'(which ? ib.out_valid : ia.out_valid), 64'd1);
            sync();
        end
    endtask

    task automatic random_phase(input bit which, input int n);
        logic [2:0]  mode;
        bit          uns;
        logic [15:0] imm;
        logic [63:0] data;
        int          off;
        for (int i = 0; i < n; i++) begin
            mode = 3'($urandom_range(0, 7));
            uns  = 1'($urandom % 2);
            imm  = 16'($urandom);
            data = {32'($urandom), 32'($urandom)};
            if (!which) data[63:32] = '0;
            off  = which ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3));
            if ($urandom % 3 == 0) off = 0;
            send(which, mode, uns, imm, data, off, model(which ? 64 : 32, which, mode, uns, imm, data, off), 1'b0);
            if ($urandom % 4 == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic ready_toggle(input bit which);
        while (!rand_done) begin
            sync();
            if (which) ib.out_ready = ($urandom % 4) != 0;
            else       ia.out_ready = ($urandom % 4) != 0;
        end
    endtask

    task automatic wait_drain(input bit which);
        for (int t = 0; t < 300 && (which ? q_b.size() : q_a.size()) > 0; t++) @(posedge clk);
        #1;
        check(which ? "b_drain" : "a_drain", 64'(which ? q_b.size() : q_a.size()), 64'd0);
    endtask

    bit          held_a, held_b;
    logic [31:0] hold_out_a;
    logic [63:0] hold_out_b;
    logic        hold_err_a, hold_err_b;

    always @(negedge clk) begin : mon_a
        logic [64:0] e;
        if (held_a && ia.out_valid) begin
            check("a_hold_out", 64'(ia.out), 64'(hold_out_a));
            check("a_hold_err", 64'(ia.err), 64'(hold_err_a));
        end
        if (ia.out_valid && ia.out_ready) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_out", 64'(q_a.size()), 64'd1);
            end else begin
                e = q_a.pop_front();
                check("a_out", 64'(ia.out), e[63:0]);
                check("a_err", 64'(ia.err), 64'(e[64]));
            end
        end
        held_a     = ia.out_valid && !ia.out_ready;
        hold_out_a = ia.out;
        hold_err_a = ia.err;
    end

    always @(negedge clk) begin : mon_b
        logic [64:0] e;
        if (held_b && ib.out_valid) begin
            check("b_hold_out", ib.out, hold_out_b);
            check("b_hold_err", 64'(ib.err), 64'(hold_err_b));
        end
        if (ib.out_valid && ib.out_ready) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_out", 64'(q_b.size()), 64'd1);
            end else begin
                e = q_b.pop_front();
                check("b_out", ib.out, e[63:0]);
                check("b_err", 64'(ib.err), 64'(e[64]));
            end
        end
        held_b     = ib.out_valid && !ib.out_ready;
        hold_out_b = ib.out;
        hold_err_b = ib.err;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    localparam logic [63:0] D32 = 64'h11C0_8007;
    localparam logic [63:0] D64 = 64'h11C0_8007_0000_0000;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ia.in_valid = 1'b0; ia.out_ready = 1'b1; ia.Mode = '0; ia.Unsigned = 1'b0;
        ia.Imm = '0; ia.Data = '0; ia.Offset = '0;
        ib.in_valid = 1'b0; ib.out_ready = 1'b1; ib.Mode = '0; ib.Unsigned = 1'b0;
        ib.Imm = '0; ib.Data = '0; ib.Offset = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_rst_out_valid", 64'(ia.out_valid), 64'd0);
        check("a_rst_in_ready", 64'(ia.in_ready), 64'd0);
        check("a_rst_err_count", 64'(ia.err_count), 64'd0);
        check("a_rst_out", 64'(ia.out), 64'd0);
        check("b_rst_out_valid", 64'(ib.out_valid), 64'd0);
        check("b_rst_in_ready", 64'(ib.in_ready), 64'd0);
        sync();
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("a_in_ready_after_rst", 64'(ia.in_ready), 64'd1);
        check("b_in_ready_after_rst", 64'(ib.in_ready), 64'd1);
        sync();

        send(0, 3'd0, 0, 16'h8000, 0, 0, {1'b0, 64'hFFFF_8000}, 1);
        send(0, 3'd0, 0, 16'hC017, 0, 0, {1'b0, 64'hFFFF_C017}, 1);
        send(0, 3'd0, 0, 16'h0017, 0, 0, {1'b0, 64'h0000_0017}, 1);
        send(0, 3'd1, 0, 16'h8007, 0, 0, {1'b0, 64'h0000_8007}, 1);
        send(0, 3'd2, 0, 16'h1234, 0, 0, {1'b0, 64'h1234_0000}, 1);
        send(0, 3'd3, 0, 16'h0, D32, 2, {1'b0, 64'hFFFF_FFC0}, 1);
        send(0, 3'd3, 1, 16'h0, D32, 2, {1'b0, 64'h0000_00C0}, 1);
        send(0, 3'd4, 0, 16'h0, D32, 0, {1'b0, 64'hFFFF_8007}, 1);
        send(0, 3'd5, 0, 16'h0, D32, 0, {1'b0, 64'h11C0_8007}, 1);
        send(0, 3'd4, 0, 16'h0, D32, 1, {1'b1, 64'h0}, 1);
        @(negedge clk);
        check("a_err_count_1", 64'(ia.err_count), 64'd1);
        sync();
        send(0, 3'd7, 0, 16'h0, D32, 0, {1'b1, 64'h0}, 1);
        @(negedge clk);
        check("a_err_count_2", 64'(ia.err_count), 64'd2);
        sync();

        rand_done = 1'b0;
        fork
            begin random_phase(0, 200); rand_done = 1'b1; end
            ready_toggle(0);
        join
        ia.out_ready = 1'b1;
        wait_drain(0);
        check("a_err_count_rand", 64'(ia.err_count), 64'(cnt_a));

        // Backpressure: A held on out, B in skid, C stalled upstream.
        sync();
        ia.out_ready = 1'b0;
        send(0, 3'd1, 0, 16'h1111, 0, 0, {1'b0, 64'h1111}, 0);
        send(0, 3'd1, 0, 16'hBEEF, 0, 0, {1'b0, 64'hBEEF}, 0);
        fork
            send(0, 3'd2, 0, 16'h00C0, 0, 0, {1'b0, 64'h00C0_0000}, 0);
            begin
                @(negedge clk);
                check("a_bp_in_ready_0", 64'(ia.in_ready), 64'd0);
                check("a_bp_hold_a", 64'(ia.out), 64'h1111);
                @(negedge clk);
                check("a_bp_in_ready_1", 64'(ia.in_ready), 64'd0);
                sync();
                ia.out_ready = 1'b1;
                @(negedge clk);
                check("a_bp_seq_a", 64'(ia.out_valid ? ia.out : 32'hDEAD_DEAD), 64'h1111);
                @(negedge clk);
                check("a_bp_seq_b", 64'(ia.out_valid ? ia.out : 32'hDEAD_DEAD), 64'hBEEF);
                @(negedge clk);
                check("a_bp_seq_c", 64'(ia.out_valid ? ia.out : 32'hDEAD_DEAD), 64'h00C0_0000);
            end
        join
        wait_drain(0);

        // Reset with output held and skid full.
        sync();
        ia.out_ready = 1'b0;
        send(0, 3'd1, 0, 16'h5555, 0, 0, {1'b0, 64'h5555}, 0);
        send(0, 3'd7, 0, 16'h0, 0, 0, {1'b1, 64'h0}, 0);
        rst_a = 1'b1;
        @(negedge clk);
        check("a_mid_rst_in_ready_comb", 64'(ia.in_ready), 64'd0);
        @(posedge clk);
        q_a.delete();
        cnt_a = 0;
        @(negedge clk);
        check("a_mid_rst_out_valid", 64'(ia.out_valid), 64'd0);
        check("a_mid_rst_out", 64'(ia.out), 64'd0);
        check("a_mid_rst_err_count", 64'(ia.err_count), 64'd0);
        check("a_mid_rst_in_ready", 64'(ia.in_ready), 64'd0);
        sync();
        rst_a = 1'b0;
        ia.out_ready = 1'b1;
        @(negedge clk);
        check("a_mid_rst_release", 64'(ia.in_ready), 64'd1);
        sync();
        send(0, 3'd0, 0, 16'hFFFF, 0, 0, {1'b0, 64'hFFFF_FFFF}, 1);

        send(1, 3'd6, 0, 16'h0, 64'h8000_0000_0000_0001, 0, {1'b0, 64'h8000_0000_0000_0001}, 1);
        send(1, 3'd5, 0, 16'h0, 64'h8000_0000_0000_0000, 0, {1'b0, 64'hFFFF_FFFF_8000_0000}, 1);
        send(1, 3'd5, 1, 16'h0, 64'h8000_0000_0000_0000, 0, {1'b0, 64'h0000_0000_8000_0000}, 1);
        send(1, 3'd3, 0, 16'h0, D64, 0, {1'b0, 64'h11}, 1);
        send(1, 3'd4, 1, 16'h0, D64, 2, {1'b0, 64'h8007}, 1);
        send(1, 3'd2, 0, 16'h8001, 0, 0, {1'b0, 64'hFFFF_FFFF_8001_0000}, 1);
        send(1, 3'd6, 0, 16'h0, D64, 4, {1'b1, 64'h0}, 1);
        @(negedge clk);
        check("b_err_count_1", 64'(ib.err_count), 64'd1);
        sync();
        for (int i = 0; i < 4; i++) send(1, 3'd7, 0, 16'h0, D64, 0, {1'b1, 64'h0}, 0);
        @(negedge clk);
        check("b_err_count_sat", 64'(ib.err_count), 64'd3);
        sync();

        rand_done = 1'b0;
        fork
            begin random_phase(1, 150); rand_done = 1'b1; end
            ready_toggle(1);
        join
        ib.out_ready = 1'b1;
        wait_drain(1);
        check("b_err_count_rand", 64'(ib.err_count), 64'(cnt_b));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
